ili9341_spi_rx: RTL

- SPI slave receiver for the 4-wire write-only link driven by the ILI9341 LCD master (mosi, cs, sck, dc).
- Oversamples the SPI lines in the system clock domain, assembles MSB-first bytes, and tags each byte as command or data.
- Decodes the window and pixel-write command subset (CASET/PASET/RAMWR) into window registers and an RGB565 pixel stream.
- Used as a loopback checker on the second FPGA board and as a bus monitor during display bring-up.

---
 rtl/ili9341_spi_rx_if.sv | 54 +++++
 rtl/ili9341_spi_rx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ili9341_spi_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : ili9341_spi_rx_if
// Description : Bus bundle for ili9341_spi_rx. Carries the four SPI lines
//               from the LCD master and the decoded byte/pixel/window outputs.
//               With ILI9341_SPI_RX_STATS_EN defined it also carries
//               pix_count and win_overrun.
// Revision    : 1.0 - initial release
// ============================================================================
interface ili9341_spi_rx_if #(
  parameter int PIX_CNT_W = 17
);
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_cs;
  logic        spi_dc;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_is_cmd;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [15:0] x_start;
  logic [15:0] x_end;
  logic [15:0] y_start;
  logic [15:0] y_end;
  logic        frame_err;
`ifdef ILI9341_SPI_RX_STATS_EN
  logic [PIX_CNT_W-1:0] pix_count;
  logic                 win_overrun;

  modport master (
    output spi_sck, spi_mosi, spi_cs, spi_dc,
    input  byte_valid, byte_data, byte_is_cmd, pix_valid, pix_data,
    input  x_start, x_end, y_start, y_end, frame_err, pix_count, win_overrun
  );
  modport slave (
    input  spi_sck, spi_mosi, spi_cs, spi_dc,
    output byte_valid, byte_data, byte_is_cmd, pix_valid, pix_data,
    output x_start, x_end, y_start, y_end, frame_err, pix_count, win_overrun
  );
`else
  modport master (
    output spi_sck, spi_mosi, spi_cs, spi_dc,
    input  byte_valid, byte_data, byte_is_cmd, pix_valid, pix_data,
    input  x_start, x_end, y_start, y_end, frame_err
  );
  modport slave (
    input  spi_sck, spi_mosi, spi_cs, spi_dc,
    output byte_valid, byte_data, byte_is_cmd, pix_valid, pix_data,
    output x_start, x_end, y_start, y_end, frame_err
  );
`endif
endinterface
`default_nettype wire

// File: rtl/ili9341_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : ili9341_spi_rx
// Description : SPI slave receiver for the ILI9341 4-wire write-only link.
//               Oversamples sck/mosi/cs/dc in the clk domain, assembles
//               MSB-first bytes tagged command/data, and decodes CASET,
//               PASET and RAMWR into window registers and an RGB565 pixel
//               stream. Define ILI9341_SPI_RX_STATS_EN to add pix_count
//               and win_overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module ili9341_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int PIX_CNT_W   = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  ili9341_spi_rx_if.slave      bus
);

  localparam logic [7:0]  c_CMD_CASET = 8'h2A;
  localparam logic [7:0]  c_CMD_PASET = 8'h2B;
  localparam logic [7:0]  c_CMD_RAMWR = 8'h2C;
  localparam logic [15:0] c_X_END_RST = 16'd239;
  localparam logic [15:0] c_Y_END_RST = 16'd319;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CASET = 2'd1,
    S_PASET = 2'd2,
    S_RAMWR = 2'd3
  } state_t;

  // Synchronizer chains; index SYNC_STAGES-1 is the settled sample.
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_dc_sync;
  logic w_sck_s, w_mosi_s, w_cs_s, w_dc_s;

  logic r_sck_d, r_cs_d;
  logic r_rise, r_mosi_s, r_dc_s;
  logic w_cs_rise;

  logic [6:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] w_byte;
  logic       w_byte_done;
  logic       w_frame_err;

  logic        r_byte_valid, r_byte_is_cmd, r_frame_err, r_pix_valid;
  logic [7:0]  r_byte_data, r_pix_hi;
  logic [15:0] r_pix_data;
  logic [15:0] r_x_start, r_x_end, r_y_start, r_y_end;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic       w_wr_x, w_wr_y, w_hi_we, w_pix_we, w_ramwr_entry;

  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_dc_s   = r_dc_sync[SYNC_STAGES-1];

  // Bring the SPI lines into the clk domain; cs idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_dc_sync   <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0],  bus.spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   bus.spi_cs};
      r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0],   bus.spi_dc};
    end
  end

  // Detect sck rising edges while selected; capture mosi/dc with the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sck_d  <= 1'b0;
      r_cs_d   <= 1'b1;
      r_rise   <= 1'b0;
      r_mosi_s <= 1'b0;
      r_dc_s   <= 1'b0;
    end else begin
      r_sck_d  <= w_sck_s;
      r_cs_d   <= w_cs_s;
      r_rise   <= w_sck_s & ~r_sck_d & ~w_cs_s;
      r_mosi_s <= w_mosi_s;
      r_dc_s   <= w_dc_s;
    end
  end

  assign w_cs_rise   = w_cs_s & ~r_cs_d;
  assign w_byte      = {r_shift, r_mosi_s};
  // A cs release wins over a coincident bit so a torn byte never completes.
  assign w_byte_done = r_rise & ~w_cs_rise & (r_bit_cnt == 3'd7);
  assign w_frame_err = w_cs_rise & (r_bit_cnt != 3'd0);

  // Shift register and bit counter; cs release realigns to a byte boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_cs_rise) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (r_rise) begin
      r_shift   <= w_byte[6:0];
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // Byte output stage and frame error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_valid  <= 1'b0;
      r_byte_data   <= '0;
      r_byte_is_cmd <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_byte_valid <= w_byte_done;
      r_frame_err  <= w_frame_err;
      if (w_byte_done) begin
        r_byte_data   <= w_byte;
        r_byte_is_cmd <= ~r_dc_s;
      end
    end
  end

  // Decoder state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Decoder next state and register write strobes. A command byte always
  // restarts decoding, even mid-sequence.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_wr_x        = 1'b0;
    w_wr_y        = 1'b0;
    w_hi_we       = 1'b0;
    w_pix_we      = 1'b0;
    w_ramwr_entry = 1'b0;
    if (w_frame_err) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 2'd0;
    end else if (w_byte_done) begin
      if (!r_dc_s) begin
        w_idx_nxt = 2'd0;
        case (w_byte)
          c_CMD_CASET: w_state_nxt = S_CASET;
          c_CMD_PASET: w_state_nxt = S_PASET;
          c_CMD_RAMWR: begin
            w_state_nxt   = S_RAMWR;
            w_ramwr_entry = 1'b1;
          end
          default:     w_state_nxt = S_IDLE;
        endcase
      end else begin
        case (r_state)
          S_CASET: begin
            w_wr_x    = 1'b1;
            w_idx_nxt = r_idx + 2'd1;
            if (r_idx == 2'd3) w_state_nxt = S_IDLE;
          end
          S_PASET: begin
            w_wr_y    = 1'b1;
            w_idx_nxt = r_idx + 2'd1;
            if (r_idx == 2'd3) w_state_nxt = S_IDLE;
          end
          S_RAMWR: begin
            if (r_idx[0]) w_pix_we = 1'b1;
            else          w_hi_we  = 1'b1;
            w_idx_nxt = {1'b0, ~r_idx[0]};
          end
          default: ;
        endcase
      end
    end
  end

  // Window registers, loaded one byte at a time, high byte first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x_start <= '0;
      r_x_end   <= c_X_END_RST;
      r_y_start <= '0;
      r_y_end   <= c_Y_END_RST;
    end else begin
      if (w_wr_x) begin
        case (r_idx)
          2'd0:    r_x_start[15:8] <= w_byte;
          2'd1:    r_x_start[7:0]  <= w_byte;
          2'd2:    r_x_end[15:8]   <= w_byte;
          default: r_x_end[7:0]    <= w_byte;
        endcase
      end
      if (w_wr_y) begin
        case (r_idx)
          2'd0:    r_y_start[15:8] <= w_byte;
          2'd1:    r_y_start[7:0]  <= w_byte;
          2'd2:    r_y_end[15:8]   <= w_byte;
          default: r_y_end[7:0]    <= w_byte;
        endcase
      end
    end
  end

  // Pixel assembly: even byte is held, odd byte completes the RGB565 word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix_hi    <= '0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
    end else begin
      r_pix_valid <= w_pix_we;
      if (w_ramwr_entry) r_pix_hi <= '0;
      else if (w_hi_we)  r_pix_hi <= w_byte;
      if (w_pix_we) r_pix_data <= {r_pix_hi, w_byte};
    end
  end

  assign bus.byte_valid  = r_byte_valid;
  assign bus.byte_data   = r_byte_data;
  assign bus.byte_is_cmd = r_byte_is_cmd;
  assign bus.pix_valid   = r_pix_valid;
  assign bus.pix_data    = r_pix_data;
  assign bus.x_start     = r_x_start;
  assign bus.x_end       = r_x_end;
  assign bus.y_start     = r_y_start;
  assign bus.y_end       = r_y_end;
  assign bus.frame_err   = r_frame_err;

`ifdef ILI9341_SPI_RX_STATS_EN
  logic [PIX_CNT_W-1:0] r_pix_count, w_pix_count_nxt;
  logic                 r_win_overrun;
  logic [16:0]          w_win_w, w_win_h;
  logic [33:0]          w_win_area;

  // Window area is computed wide enough that no window size can overflow.
  assign w_win_w         = {1'b0, r_x_end} - {1'b0, r_x_start} + 17'd1;
  assign w_win_h         = {1'b0, r_y_end} - {1'b0, r_y_start} + 17'd1;
  assign w_win_area      = 34'(w_win_w) * 34'(w_win_h);
  assign w_pix_count_nxt = (&r_pix_count) ? r_pix_count
                                          : r_pix_count + PIX_CNT_W'(1);

  // Saturating pixel counter and sticky overrun flag, restarted by RAMWR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix_count   <= '0;
      r_win_overrun <= 1'b0;
    end else if (w_ramwr_entry) begin
      r_pix_count   <= '0;
      r_win_overrun <= 1'b0;
    end else if (w_pix_we) begin
      r_pix_count <= w_pix_count_nxt;
      if (34'(w_pix_count_nxt) > w_win_area) r_win_overrun <= 1'b1;
    end
  end

  assign bus.pix_count   = r_pix_count;
  assign bus.win_overrun = r_win_overrun;
`endif

endmodule
`default_nettype wire
